cache_arbiter: RTL and testbench

//   Shares the single byte-wide cache device port between two requesters: port 0 (CPU) and port 1 (WOPI).

---
 rtl/cache_arbiter_if.sv | 58 +++++
 rtl/cache_arbiter.sv | 141 ++++++++++++++
 tb/tb_cache_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : cache_arbiter_if
// Brief   : Bundles the two requester ports and the cache device port seen
//           by cache_arbiter. The slave modport is the arbiter side. The
//           master modport is the environment side: requesters plus cache.
// Rev     : 1.0  initial release
// ============================================================================
interface cache_arbiter_if #(
  parameter int ADDR_W = 17
);
  // port 0 (CPU)
  logic [ADDR_W-1:0] r0_address;
  logic [7:0]        r0_data_write;
  logic              r0_read_req;
  logic              r0_write_req;
  logic [7:0]        r0_data_read;
  logic              r0_read_ack;
  logic              r0_write_ack;
  // port 1 (WOPI)
  logic [ADDR_W-1:0] r1_address;
  logic [7:0]        r1_data_write;
  logic              r1_read_req;
  logic              r1_write_req;
  logic [7:0]        r1_data_read;
  logic              r1_read_ack;
  logic              r1_write_ack;
  // cache device side
  logic [ADDR_W-1:0] ca_address;
  logic [7:0]        ca_data_write;
  logic              ca_read_req;
  logic              ca_write_req;
  logic [7:0]        ca_data_read;
  logic              ca_read_ack;
  logic              ca_write_ack;
  logic              busy;

  modport slave (
    input  r0_address, r0_data_write, r0_read_req, r0_write_req,
    output r0_data_read, r0_read_ack, r0_write_ack,
    input  r1_address, r1_data_write, r1_read_req, r1_write_req,
    output r1_data_read, r1_read_ack, r1_write_ack,
    output ca_address, ca_data_write, ca_read_req, ca_write_req,
    input  ca_data_read, ca_read_ack, ca_write_ack,
    output busy
  );

  modport master (
    output r0_address, r0_data_write, r0_read_req, r0_write_req,
    input  r0_data_read, r0_read_ack, r0_write_ack,
    output r1_address, r1_data_write, r1_read_req, r1_write_req,
    input  r1_data_read, r1_read_ack, r1_write_ack,
    input  ca_address, ca_data_write, ca_read_req, ca_write_req,
    output ca_data_read, ca_read_ack, ca_write_ack,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cache_arbiter
// Brief   : Shares one byte-wide cache port between port 0 (CPU) and port 1
//           (WOPI). One transaction at a time, issued as a single-cycle
//           request pulse. Address/data are held until the cache is idle,
//           and ack/read data are returned only to the owning port.
// Rev     : 1.0  initial release
// ============================================================================
module cache_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int HOLDOFF    = 9,
  parameter int FIXED_PRIO = 0
) (
  input  logic           sys_clk,
  input  logic           reset_n,
  cache_arbiter_if.slave bus
);

  // Holdoff counter must hold HOLDOFF-1; HOLDOFF >= 9 keeps this >= 4 bits.
  localparam int CNT_W = $clog2(HOLDOFF);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_CAPTURE  = 3'd3,
    S_HOLDOFF  = 3'd4
  } state_t;

  state_t           state;
  logic             owner;     // 0 = port 0, 1 = port 1
  logic             op_write;  // op issued to the cache for the owner
  logic             rr;        // port preferred on the next tie
  logic [CNT_W-1:0] cnt;

  logic req0;
  logic req1;
  logic pick;
  logic pick_write;

  // Choose the owner for a grant from IDLE; read wins when both reqs are up.
  always_comb begin
    req0 = bus.r0_read_req | bus.r0_write_req;
    req1 = bus.r1_read_req | bus.r1_write_req;
    pick = 1'b0;
    if (req0 && req1) begin
      pick = (FIXED_PRIO != 0) ? 1'b0 : rr;
    end else if (req1) begin
      pick = 1'b1;
    end
    pick_write = pick ? (bus.r1_write_req & ~bus.r1_read_req)
                      : (bus.r0_write_req & ~bus.r0_read_req);
  end

  // Transaction sequencer; every output is registered here.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      owner             <= 1'b0;
      op_write          <= 1'b0;
      rr                <= 1'b0;
      cnt               <= '0;
      bus.busy          <= 1'b0;
      bus.ca_address    <= '0;
      bus.ca_data_write <= '0;
      bus.ca_read_req   <= 1'b0;
      bus.ca_write_req  <= 1'b0;
      bus.r0_data_read  <= '0;
      bus.r0_read_ack   <= 1'b0;
      bus.r0_write_ack  <= 1'b0;
      bus.r1_data_read  <= '0;
      bus.r1_read_ack   <= 1'b0;
      bus.r1_write_ack  <= 1'b0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      bus.ca_read_req  <= 1'b0;
      bus.ca_write_req <= 1'b0;
      bus.r0_read_ack  <= 1'b0;
      bus.r0_write_ack <= 1'b0;
      bus.r1_read_ack  <= 1'b0;
      bus.r1_write_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            owner             <= pick;
            op_write          <= pick_write;
            rr                <= ~pick;
            bus.ca_address    <= pick ? bus.r1_address : bus.r0_address;
            bus.ca_data_write <= pick ? bus.r1_data_write : bus.r0_data_write;
            bus.ca_read_req   <= ~pick_write;
            bus.ca_write_req  <= pick_write;
            bus.busy          <= 1'b1;
            state             <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // An ack of the other type than the issued op is ignored.
          if (!op_write && bus.ca_read_ack) begin
            state <= S_CAPTURE;
          end else if (op_write && bus.ca_write_ack) begin
            if (owner) bus.r1_write_ack <= 1'b1;
            else       bus.r0_write_ack <= 1'b1;
            cnt   <= CNT_W'(HOLDOFF - 1);
            state <= S_HOLDOFF;
          end
        end
        S_CAPTURE: begin
          // Cache read data is valid in this cycle for both hit and miss.
          if (owner) begin
            bus.r1_data_read <= bus.ca_data_read;
            bus.r1_read_ack  <= 1'b1;
          end else begin
            bus.r0_data_read <= bus.ca_data_read;
            bus.r0_read_ack  <= 1'b1;
          end
          cnt   <= CNT_W'(HOLDOFF - 1);
          state <= S_HOLDOFF;
        end
        S_HOLDOFF: begin
          // Cache may still be finishing a miss fill or byte store.
          if (cnt == '0) begin
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_arbiter
// Brief   : Directed self-checking bench for cache_arbiter. One round-robin
//           instance (ifa) and one fixed-priority instance (ifb), each with
//           a simple cache responder.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_W(17)) ifa ();
  cache_arbiter_if #(.ADDR_W(17)) ifb ();

  cache_arbiter #(.ADDR_W(17), .HOLDOFF(9), .FIXED_PRIO(0)) dut_rr (
    .sys_clk(clk), .reset_n(reset_n), .bus(ifa));
  cache_arbiter #(.ADDR_W(17), .HOLDOFF(9), .FIXED_PRIO(1)) dut_fp (
    .sys_clk(clk), .reset_n(reset_n), .bus(ifb));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // cache model A settings / observations
  int         lat_a   = 1;
  int         tail_a  = 0;
  logic [7:0] rdata_a = 8'h00;
  logic       pending_a, op_a;
  int         cnt_a, tailc_a;
  int         viol_a = 0, ack_cyc_a = 0, gap_a = 0;
  int n_r0r = 0, n_r0w = 0, n_r1r = 0, n_r1w = 0, n_car = 0, n_caw = 0;
  logic [16:0] glog_a[$];
  logic [16:0] glog_b[$];
  logic pending_b, op_b;

  always @(posedge clk) cyc <= cyc + 1;

  // Cache responder A: ack after lat_a cycles, then stays busy tail_a cycles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifa.ca_read_ack  <= 1'b0;
      ifa.ca_write_ack <= 1'b0;
      ifa.ca_data_read <= 8'h00;
      pending_a        <= 1'b0;
      op_a             <= 1'b0;
      cnt_a            <= 0;
      tailc_a          <= 0;
    end else begin
      ifa.ca_read_ack  <= 1'b0;
      ifa.ca_write_ack <= 1'b0;
      if (tailc_a > 0) tailc_a <= tailc_a - 1;
      if (ifa.ca_read_req || ifa.ca_write_req) begin
        if (pending_a || tailc_a > 0) viol_a <= viol_a + 1;
        pending_a <= 1'b1;
        cnt_a     <= lat_a;
        op_a      <= ifa.ca_write_req;
        gap_a     <= cyc - ack_cyc_a;
      end else if (pending_a) begin
        if (cnt_a <= 1) begin
          pending_a <= 1'b0;
          if (op_a) ifa.ca_write_ack <= 1'b1;
          else begin
            ifa.ca_read_ack  <= 1'b1;
            ifa.ca_data_read <= rdata_a;
          end
          ack_cyc_a <= cyc;
          tailc_a   <= tail_a;
        end else begin
          cnt_a <= cnt_a - 1;
        end
      end
    end
  end

  // Cache responder B: fixed one-cycle latency.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifb.ca_read_ack  <= 1'b0;
      ifb.ca_write_ack <= 1'b0;
      ifb.ca_data_read <= 8'h00;
      pending_b        <= 1'b0;
      op_b             <= 1'b0;
    end else begin
      ifb.ca_read_ack  <= 1'b0;
      ifb.ca_write_ack <= 1'b0;
      if (ifb.ca_read_req || ifb.ca_write_req) begin
        pending_b <= 1'b1;
        op_b      <= ifb.ca_write_req;
      end else if (pending_b) begin
        pending_b <= 1'b0;
        if (op_b) ifb.ca_write_ack <= 1'b1;
        else begin
          ifb.ca_read_ack  <= 1'b1;
          ifb.ca_data_read <= 8'h22;
        end
      end
    end
  end

  // Pulse counters and grant logs.
  always @(posedge clk) begin
    if (ifa.r0_read_ack)  n_r0r <= n_r0r + 1;
    if (ifa.r0_write_ack) n_r0w <= n_r0w + 1;
    if (ifa.r1_read_ack)  n_r1r <= n_r1r + 1;
    if (ifa.r1_write_ack) n_r1w <= n_r1w + 1;
    if (ifa.ca_read_req)  n_car <= n_car + 1;
    if (ifa.ca_write_req) n_caw <= n_caw + 1;
    if (ifa.ca_read_req || ifa.ca_write_req) glog_a.push_back(ifa.ca_address);
    if (ifb.ca_read_req || ifb.ca_write_req) glog_b.push_back(ifb.ca_address);
  end

  task automatic clear_reqs();
    ifa.r0_read_req = 0; ifa.r0_write_req = 0; ifa.r1_read_req = 0; ifa.r1_write_req = 0;
    ifb.r0_read_req = 0; ifb.r0_write_req = 0; ifb.r1_read_req = 0; ifb.r1_write_req = 0;
  endtask

  task automatic do_reset();
    clear_reqs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle_a(input string tag);
    int i = 0;
    while (ifa.busy && i < 60) begin @(negedge clk); i++; end
    n_checks++;
    if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_timeout: busy=%b want 0", tag, ifa.busy); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({ifa.busy, ifa.ca_read_req, ifa.ca_write_req, ifa.r0_read_ack, ifa.r0_write_ack,
         ifa.r1_read_ack, ifa.r1_write_ack} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000000", {ifa.busy, ifa.ca_read_req,
        ifa.ca_write_req, ifa.r0_read_ack, ifa.r0_write_ack, ifa.r1_read_ack, ifa.r1_write_ack});
    end
    n_checks++;
    if ({ifa.ca_address, ifa.ca_data_write, ifa.r0_data_read, ifa.r1_data_read} !== '0) begin
      n_fail++; $display("FAIL reset_data: addr=%h dw=%h d0=%h d1=%h want 0", ifa.ca_address,
        ifa.ca_data_write, ifa.r0_data_read, ifa.r1_data_read);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: a=%b b=%b want 0", ifa.busy, ifb.busy);
    end
  endtask

  task automatic test_single_read();
    int s_r1, s_car, i, lat;
    bit ok;
    s_r1 = n_r1r + n_r1w; s_car = n_car;
    lat_a = 1; rdata_a = 8'h5A;
    ifa.r0_address = 17'h00010; ifa.r0_read_req = 1'b1;
    ok = 0; i = 0; lat = 0;
    while (!ok && i < 40) begin
      @(negedge clk); i++;
      if (ifa.r0_read_ack) begin ok = 1; lat = i; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL read1_ack_timeout: no r0_read_ack in 40 cycles"); end
    n_checks++;
    if (ifa.r0_data_read !== 8'h5A) begin n_fail++; $display("FAIL read1_data: got %h want 5a", ifa.r0_data_read); end
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL read1_latency: ack at negedge %0d want 5", lat); end
    ifa.r0_read_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifa.r0_read_ack !== 1'b0 || ifa.r0_data_read !== 8'h5A) begin
      n_fail++; $display("FAIL read1_pulse_hold: ack=%b data=%h want 0/5a", ifa.r0_read_ack, ifa.r0_data_read);
    end
    wait_idle_a("read1");
    n_checks++;
    if ((n_r1r + n_r1w - s_r1) !== 0 || (n_car - s_car) !== 1) begin
      n_fail++; $display("FAIL read1_counts: r1_acks=%0d ca_rreq=%0d want 0/1", n_r1r + n_r1w - s_r1, n_car - s_car);
    end
  endtask

  task automatic test_round_robin();
    int base, s0, s1, done, i;
    logic [16:0] exp_addr[4];
    do_reset();
    exp_addr = '{17'h00100, 17'h00200, 17'h00100, 17'h00200};
    base = glog_a.size(); s0 = n_r0r; s1 = n_r1r;
    lat_a = 1; rdata_a = 8'h11;
    ifa.r0_address = 17'h00100; ifa.r1_address = 17'h00200;
    ifa.r0_read_req = 1'b1; ifa.r1_read_req = 1'b1;
    done = 0; i = 0;
    while (done < 4 && i < 200) begin
      @(negedge clk); i++;
      if (ifa.r0_read_ack) begin ifa.r0_read_req = 1'b0; done++; end
      if (ifa.r1_read_ack) begin ifa.r1_read_req = 1'b0; done++; end
      if (!ifa.busy && done < 4) begin ifa.r0_read_req = 1'b1; ifa.r1_read_req = 1'b1; end
    end
    n_checks++;
    if (done !== 4) begin n_fail++; $display("FAIL rr_timeout: %0d acks want 4", done); end
    wait_idle_a("rr");
    n_checks++;
    if ((glog_a.size() - base) !== 4) begin
      n_fail++; $display("FAIL rr_grant_count: got %0d want 4", glog_a.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (glog_a[base + k] !== exp_addr[k]) begin
          n_fail++; $display("FAIL rr_grant%0d: addr %h want %h", k, glog_a[base + k], exp_addr[k]);
        end
      end
    end
    n_checks++;
    if ((n_r0r - s0) !== 2 || (n_r1r - s1) !== 2) begin
      n_fail++; $display("FAIL rr_acks: r0=%0d r1=%0d want 2/2", n_r0r - s0, n_r1r - s1);
    end
  endtask

  task automatic test_fixed_prio();
    int base, i, first;
    bit a0, a1;
    logic [16:0] exp_addr[3];
    do_reset();
    exp_addr = '{17'h00100, 17'h00100, 17'h00200};
    base = glog_b.size();
    ifb.r0_address = 17'h00100; ifb.r1_address = 17'h00200;
    // lone port 0 first, so a round-robin pointer would now favour port 1
    ifb.r0_read_req = 1'b1;
    i = 0;
    while (!ifb.r0_read_ack && i < 40) begin @(negedge clk); i++; end
    ifb.r0_read_req = 1'b0;
    i = 0;
    while (ifb.busy && i < 40) begin @(negedge clk); i++; end
    ifb.r0_read_req = 1'b1; ifb.r1_read_req = 1'b1;
    a0 = 0; a1 = 0; first = -1; i = 0;
    while (!(a0 && a1 && !ifb.busy) && i < 100) begin
      @(negedge clk); i++;
      if (ifb.r0_read_ack) begin a0 = 1; ifb.r0_read_req = 1'b0; if (first < 0) first = 0; end
      if (ifb.r1_read_ack) begin a1 = 1; ifb.r1_read_req = 1'b0; if (first < 0) first = 1; end
    end
    n_checks++;
    if (first !== 0) begin n_fail++; $display("FAIL fp_tie_winner: port %0d want 0", first); end
    n_checks++;
    if ((glog_b.size() - base) !== 3) begin
      n_fail++; $display("FAIL fp_grant_count: got %0d want 3", glog_b.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (glog_b[base + k] !== exp_addr[k]) begin
          n_fail++; $display("FAIL fp_grant%0d: addr %h want %h", k, glog_b[base + k], exp_addr[k]);
        end
      end
    end
  endtask

  task automatic test_write();
    int s_car, s_caw, s_r1w, s_oth, i, busy_cyc, hold_bad;
    bit seen, fin;
    s_car = n_car; s_caw = n_caw; s_r1w = n_r1w; s_oth = n_r0r + n_r0w + n_r1r;
    lat_a = 2;
    ifa.r1_address = 17'h1FFFF; ifa.r1_data_write = 8'hA5; ifa.r1_write_req = 1'b1;
    seen = 0; fin = 0; i = 0; busy_cyc = 0; hold_bad = 0;
    while (!fin && i < 60) begin
      @(negedge clk); i++;
      if (ifa.busy) begin
        seen = 1; busy_cyc++;
        if (ifa.ca_address !== 17'h1FFFF || ifa.ca_data_write !== 8'hA5) hold_bad++;
      end else if (seen) fin = 1;
      if (ifa.r1_write_ack) ifa.r1_write_req = 1'b0;
    end
    n_checks++;
    if (!fin) begin n_fail++; $display("FAIL wr_timeout: transaction did not finish"); end
    n_checks++;
    if (hold_bad !== 0) begin n_fail++; $display("FAIL wr_hold: %0d cycles bad addr/data want 0", hold_bad); end
    n_checks++;
    if (busy_cyc !== 13) begin n_fail++; $display("FAIL wr_busy_len: %0d cycles want 13", busy_cyc); end
    n_checks++;
    if ((n_caw - s_caw) !== 1 || (n_car - s_car) !== 0) begin
      n_fail++; $display("FAIL wr_cache_req: wreq=%0d rreq=%0d want 1/0", n_caw - s_caw, n_car - s_car);
    end
    n_checks++;
    if ((n_r1w - s_r1w) !== 1 || (n_r0r + n_r0w + n_r1r - s_oth) !== 0) begin
      n_fail++; $display("FAIL wr_acks: r1w=%0d others=%0d want 1/0", n_r1w - s_r1w, n_r0r + n_r0w + n_r1r - s_oth);
    end
  endtask

  task automatic test_miss_holdoff();
    int s_v, s_car, s0, s1, i;
    bit a0, a1;
    s_v = viol_a; s_car = n_car; s0 = n_r0r; s1 = n_r1r;
    lat_a = 3; tail_a = 5; rdata_a = 8'h6E;
    ifa.r0_address = 17'h00020; ifa.r1_address = 17'h00030;
    ifa.r0_read_req = 1'b1; ifa.r1_read_req = 1'b1;
    a0 = 0; a1 = 0; i = 0;
    while (!(a0 && a1 && !ifa.busy) && i < 100) begin
      @(negedge clk); i++;
      if (ifa.r0_read_ack) begin a0 = 1; ifa.r0_read_req = 1'b0; end
      if (ifa.r1_read_ack) begin a1 = 1; ifa.r1_read_req = 1'b0; end
    end
    n_checks++;
    if (!(a0 && a1)) begin n_fail++; $display("FAIL miss_timeout: acks r0=%b r1=%b want 1/1", a0, a1); end
    n_checks++;
    if ((viol_a - s_v) !== 0) begin n_fail++; $display("FAIL miss_busy_violation: %0d early reqs want 0", viol_a - s_v); end
    n_checks++;
    if (gap_a !== 13) begin n_fail++; $display("FAIL miss_spacing: ack-to-req %0d cycles want 13", gap_a); end
    n_checks++;
    if ((n_car - s_car) !== 2 || (n_r0r - s0) !== 1 || (n_r1r - s1) !== 1) begin
      n_fail++; $display("FAIL miss_counts: rreq=%0d r0=%0d r1=%0d want 2/1/1", n_car - s_car, n_r0r - s0, n_r1r - s1);
    end
    tail_a = 0;
  endtask

  task automatic test_reset_mid();
    int s_car, i;
    lat_a = 6;
    ifa.r0_address = 17'h00055; ifa.r0_data_write = 8'h3C; ifa.r0_read_req = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ifa.busy !== 1'b1 || ifa.ca_address !== 17'h00055) begin
      n_fail++; $display("FAIL rstmid_pre: busy=%b addr=%h want 1/00055", ifa.busy, ifa.ca_address);
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ifa.busy, ifa.ca_read_req, ifa.ca_write_req, ifa.r0_read_ack, ifa.r0_write_ack,
         ifa.r1_read_ack, ifa.r1_write_ack} !== 7'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: busy=%b rreq=%b wreq=%b want 0", ifa.busy, ifa.ca_read_req, ifa.ca_write_req);
    end
    n_checks++;
    if ({ifa.ca_address, ifa.ca_data_write, ifa.r0_data_read, ifa.r1_data_read} !== '0) begin
      n_fail++; $display("FAIL rstmid_data: addr=%h dw=%h d0=%h d1=%h want 0", ifa.ca_address,
        ifa.ca_data_write, ifa.r0_data_read, ifa.r1_data_read);
    end
    ifa.r0_read_req = 1'b0;
    s_car = n_car;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ((n_car - s_car) !== 0) begin n_fail++; $display("FAIL rstmid_no_req: %0d cache reqs want 0", n_car - s_car); end
    lat_a = 1; rdata_a = 8'h9C;
    ifa.r1_address = 17'h00300; ifa.r1_read_req = 1'b1;
    i = 0;
    while (!ifa.r1_read_ack && i < 40) begin @(negedge clk); i++; end
    n_checks++;
    if (ifa.r1_read_ack !== 1'b1 || ifa.r1_data_read !== 8'h9C) begin
      n_fail++; $display("FAIL rstmid_after: ack=%b data=%h want 1/9c", ifa.r1_read_ack, ifa.r1_data_read);
    end
    ifa.r1_read_req = 1'b0;
    wait_idle_a("rstmid");
  endtask

  task automatic test_read_write_both();
    int s_car, s_caw, s_r0w, i;
    s_car = n_car; s_caw = n_caw; s_r0w = n_r0w;
    lat_a = 1; rdata_a = 8'hC3;
    ifa.r0_address = 17'h00044; ifa.r0_data_write = 8'h77;
    ifa.r0_read_req = 1'b1; ifa.r0_write_req = 1'b1;
    i = 0;
    while (!(ifa.r0_read_ack || ifa.r0_write_ack) && i < 40) begin @(negedge clk); i++; end
    n_checks++;
    if (ifa.r0_read_ack !== 1'b1 || ifa.r0_data_read !== 8'hC3) begin
      n_fail++; $display("FAIL rw_read: ack=%b data=%h want 1/c3", ifa.r0_read_ack, ifa.r0_data_read);
    end
    ifa.r0_read_req = 1'b0; ifa.r0_write_req = 1'b0;
    wait_idle_a("rw");
    n_checks++;
    if ((n_car - s_car) !== 1 || (n_caw - s_caw) !== 0 || (n_r0w - s_r0w) !== 0) begin
      n_fail++; $display("FAIL rw_counts: rreq=%0d wreq=%0d r0w=%0d want 1/0/0", n_car - s_car, n_caw - s_caw, n_r0w - s_r0w);
    end
  endtask

  initial begin
    ifa.r0_address = '0; ifa.r0_data_write = '0; ifa.r1_address = '0; ifa.r1_data_write = '0;
    ifb.r0_address = '0; ifb.r0_data_write = '0; ifb.r1_address = '0; ifb.r1_data_write = '0;
    clear_reqs();
    reset_n = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_prio();
    test_write();
    test_miss_holdoff();
    test_reset_mid();
    test_read_write_both();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
